// File: rtl/axi_lite_ram.sv
// axi_lite_ram: AXI4-Lite slave RAM with byte strobes, SLVERR decode and round-robin read/write arbitration.
// Define AXI_LITE_RAM_CLEAR_EN to zero the whole array on reset (otherwise the array has no reset).
module axi_lite_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 2048
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(STRB_WIDTH);
  localparam int IDX = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RDATA, WCOLLECT, WRESP} state_t;
  state_t state, state_nx;
  logic last_wr, last_wr_nx;
  logic aw_held, w_held, aw_ok_q;
  logic [IDX-1:0] aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic rd_grant, wr_grant, wr_phase, aw_hs, w_hs, commit;
  logic [IDX-1:0] ar_idx, aw_idx, wr_idx;
  logic ar_ok, aw_ok, wr_ok;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic unused_addr;
  assign ar_idx = araddr[OFFS +: IDX];
  assign aw_idx = awaddr[OFFS +: IDX];
  assign ar_ok = (araddr >> (OFFS + IDX)) == '0;
  assign aw_ok = (awaddr >> (OFFS + IDX)) == '0;
  assign unused_addr = ^{araddr[OFFS-1:0], awaddr[OFFS-1:0]};
  assign wr_idx = aw_held ? aw_idx_q : aw_idx;
  assign wr_ok = aw_held ? aw_ok_q : aw_ok;
  assign wr_data = w_held ? wdata_q : wdata;
  assign wr_strb = w_held ? wstrb_q : wstrb;
  assign rvalid = state == RDATA;
  assign bvalid = state == WRESP;
  always_comb begin
    rd_grant = areset_n && state == IDLE && arvalid && (!(awvalid || wvalid) || last_wr);
    wr_grant = areset_n && state == IDLE && !rd_grant && (awvalid || wvalid);
    wr_phase = wr_grant || (areset_n && state == WCOLLECT);
    arready = rd_grant;
    awready = wr_phase && !aw_held;
    wready = wr_phase && !w_held;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    commit = (aw_held || aw_hs) && (w_held || w_hs);
    last_wr_nx = wr_grant ? 1'b1 : rd_grant ? 1'b0 : last_wr;
    state_nx = rd_grant ? RDATA :
               wr_phase ? (commit ? WRESP : WCOLLECT) :
               (state == RDATA && rready) || (state == WRESP && bready) ? IDLE : state;
  end
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state <= IDLE;
      last_wr <= 1'b1;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      rdata <= '0;
      rresp <= 2'b00;
      bresp <= 2'b00;
    end else begin
      state <= state_nx;
      last_wr <= last_wr_nx;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx_q <= aw_idx;
        aw_ok_q <= aw_ok;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) bresp <= wr_ok ? 2'b00 : 2'b10;
      if (state == WRESP && bready) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
      end
      if (rd_grant) begin
        rdata <= ar_ok ? mem[ar_idx] : '0;
        rresp <= ar_ok ? 2'b00 : 2'b10;
      end else if (state == RDATA && rready) begin
        rdata <= '0;
      end
    end
  end
`ifdef AXI_LITE_RAM_CLEAR_EN
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int j = 0; j < STRB_WIDTH; j++) if (wr_strb[j]) mem[wr_idx][8*j +: 8] <= wr_data[8*j +: 8];
    end
  end
`else
  always_ff @(posedge aclk) begin
    if (commit && wr_ok) begin
      for (int j = 0; j < STRB_WIDTH; j++) if (wr_strb[j]) mem[wr_idx][8*j +: 8] <= wr_data[8*j +: 8];
    end
  end
`endif
endmodule
